// File: rtl/psum_acc_pkg.sv
// Shared types and lane-width helpers for the psum accumulation bank.
package psum_acc_pkg;

  typedef enum logic {
    OP_ACC   = 1'b0,
    OP_DRAIN = 1'b1
  } op_e;

  // Control half of the S1 pipeline register; address and data ride alongside.
  typedef struct packed {
    logic vld;
    op_e  op;
    logic first;
    logic relu;
    logic in_range;
  } s1_ctrl_t;

  function automatic logic signed [63:0] lane_max(input int bw);
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] lane_min(input int bw);
    return -(64'sd1 <<< (bw - 1));
  endfunction

endpackage

// File: rtl/psum_acc_bank_lane_add.sv
// Single signed lane add; saturates when PSUM_ACC_SAT_EN is defined, wraps otherwise.
module psum_lane_add
  import psum_acc_pkg::*;
#(
  parameter int bw = 16
) (
  input  logic signed [bw-1:0] a,
  input  logic signed [bw-1:0] b,
  output logic signed [bw-1:0] sum
);

`ifdef PSUM_ACC_SAT_EN
  localparam logic signed [bw-1:0] LMAX = bw'(lane_max(bw));
  localparam logic signed [bw-1:0] LMIN = bw'(lane_min(bw));

  logic signed [bw:0] wide;
  assign wide = {a[bw-1], a} + {b[bw-1], b};

  // Sign bits disagree only when the true sum left the lane range.
  always_comb begin
    sum = wide[bw-1:0];
    if (wide[bw] != wide[bw-1]) sum = wide[bw] ? LMIN : LMAX;
  end
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/psum_acc_bank.sv
// Two-stage psum bank: S0 reads memory, S1 accumulates/writes or drains (ReLU optional).
// Optional lane saturation via `PSUM_ACC_SAT_EN; 1-deep write-to-read hazard is forwarded.
module psum_acc_bank
  import psum_acc_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 2048,
  parameter int addr_w  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic [addr_w-1:0]        in_addr,
  input  logic [psum_bw*col-1:0]   in_data,
  output logic                     in_ready,
  input  logic                     rd_req,
  input  logic [addr_w-1:0]        rd_addr,
  output logic                     rd_ready,
  input  logic                     relu_en,
  output logic                     out_valid,
  output logic [psum_bw*col-1:0]   out_data
);

  localparam int DW = psum_bw * col;

  logic [DW-1:0]     mem [depth];
  logic [DW-1:0]     rd_q;
  logic [addr_w-1:0] raddr;
  logic              raddr_ok;
  logic              acc_go, drn_go;

  s1_ctrl_t          s1;
  logic [addr_w-1:0] s1_addr;
  logic [DW-1:0]     s1_data;

  logic              lw_vld;
  logic [addr_w-1:0] lw_addr;
  logic [DW-1:0]     lw_data;

  logic [DW-1:0]     opnd, result, drain_val, out_hold;
  logic              wr_en, drain_live;

  assign in_ready = 1'b1;
  assign rd_ready = !in_valid;
  assign acc_go   = in_valid;
  assign drn_go   = rd_req && !in_valid;
  assign raddr    = in_valid ? in_addr : rd_addr;
  assign raddr_ok = int'(raddr) < depth;

  // Reads and writes share one edge; a colliding read sees the old row.
  always_ff @(posedge clk) begin
    if (raddr_ok) rd_q <= mem[raddr];
    if (wr_en) mem[s1_addr] <= result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1.vld      <= acc_go || drn_go;
      s1.op       <= acc_go ? OP_ACC : OP_DRAIN;
      s1.first    <= in_first;
      s1.relu     <= relu_en;
      s1.in_range <= raddr_ok;
    end
  end

  always_ff @(posedge clk) begin
    s1_addr <= raddr;
    s1_data <= in_data;
  end

  // The row written at the previous edge is not yet visible through rd_q.
  assign opnd = (lw_vld && lw_addr == s1_addr) ? lw_data : rd_q;

  for (genvar k = 0; k < col; k++) begin : g_lane
    logic [psum_bw-1:0] sum_l;

    psum_lane_add #(.bw(psum_bw)) u_add (
      .a   (opnd[k*psum_bw +: psum_bw]),
      .b   (s1_data[k*psum_bw +: psum_bw]),
      .sum (sum_l)
    );

    assign result[k*psum_bw +: psum_bw] = s1.first ? s1_data[k*psum_bw +: psum_bw] : sum_l;
    assign drain_val[k*psum_bw +: psum_bw] =
      (!s1.in_range || (s1.relu && opnd[k*psum_bw + psum_bw - 1])) ? '0 : opnd[k*psum_bw +: psum_bw];
  end

  assign wr_en      = s1.vld && s1.op == OP_ACC && s1.in_range && !reset;
  assign drain_live = s1.vld && s1.op == OP_DRAIN && !reset;

  always_ff @(posedge clk) begin
    if (reset) lw_vld <= 1'b0;
    else       lw_vld <= wr_en;
    if (wr_en) begin
      lw_addr <= s1_addr;
      lw_data <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           out_hold <= '0;
    else if (drain_live) out_hold <= drain_val;
  end

  assign out_valid = drain_live;
  assign out_data  = drain_live ? drain_val : out_hold;

endmodule

// File: tb/tb_psum_acc_bank.sv
// Scoreboard bench for psum_acc_bank: drains push expected rows, a negedge monitor pops them.
module tb_psum_acc_bank;

  localparam int COL = 8, BW = 16, DEPTH = 2000, AW = 11;
  localparam int DW = COL * BW;

  logic          clk = 0;
  logic          reset;
  logic          in_valid, in_first, rd_req, relu_en;
  logic [AW-1:0] in_addr, rd_addr;
  logic [DW-1:0] in_data;
  logic          in_ready, rd_ready, out_valid;
  logic [DW-1:0] out_data;

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  bit            known [DEPTH];

  always #5 clk = ~clk;

  psum_acc_bank #(.col(COL), .psum_bw(BW), .depth(DEPTH), .addr_w(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_first(in_first), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .relu_en(relu_en), .out_valid(out_valid), .out_data(out_data)
  );

  function automatic logic [BW-1:0] lane_acc(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW:0] w;
    w = {a[BW-1], a} + {b[BW-1], b};
`ifdef PSUM_ACC_SAT_EN
    if (w[BW] != w[BW-1]) return w[BW] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
`endif
    return w[BW-1:0];
  endfunction

  function automatic logic [DW-1:0] row_acc(input logic [DW-1:0] old, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = lane_acc(old[k*BW +: BW], d[k*BW +: BW]);
    return r;
  endfunction

  function automatic logic [DW-1:0] row_relu(input logic [DW-1:0] x, input logic relu);
    logic [DW-1:0] r;
    r = x;
    for (int k = 0; k < COL; k++) if (relu && x[k*BW + BW - 1]) r[k*BW +: BW] = '0;
    return r;
  endfunction

  function automatic logic [DW-1:0] splat(input logic [BW-1:0] v);
    return {COL{v}};
  endfunction

  // Check each drain result in the cycle after acceptance.
  always @(negedge clk) begin
    if (out_valid) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL drain_unexpected: out_valid=1 data=%h, required no drain", out_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          mismatched++;
          $display("FAIL drain_data: got %h, required %h", out_data, e);
        end
      end
    end
  end

  task automatic clear_inputs();
    in_valid = 0; in_first = 0; in_addr = '0; in_data = '0;
    rd_req = 0; rd_addr = '0; relu_en = 0;
  endtask

  // One cycle of stimulus; the model is updated in issue order.
  task automatic step(input logic v, input logic first, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic rq, input logic [AW-1:0] ra,
                      input logic relu, input bit upd = 1);
    in_valid = v; in_first = first; in_addr = a; in_data = d;
    rd_req = rq; rd_addr = ra; relu_en = relu;
    if (v && upd && int'(a) < DEPTH) begin
      ref_mem[a] = first ? d : row_acc(ref_mem[a], d);
      known[a] = 1;
    end
    if (rq && !v) exp_q.push_back(int'(ra) < DEPTH ? row_relu(ref_mem[ra], relu) : '0);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    compared++; if (out_data !== '0) begin mismatched++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL in_ready: got %b, required 1", in_ready); end
    compared++; if (rd_ready !== 1'b1) begin mismatched++; $display("FAIL rd_ready_idle: got %b, required 1", rd_ready); end
  endtask

  task automatic test_first_acc();
    step(1, 1, 5, splat(16'd3), 0, 0, 0);
    idle(2);
    step(1, 0, 5, splat(16'd4), 0, 0, 0);
    step(0, 0, 0, '0, 1, 5, 0);
    compared++;
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL drain_latency: out_valid=%b, required 1", out_valid); end
    idle(1);
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL drain_one_cycle: out_valid=%b, required 0", out_valid); end
    compared++;
    if (out_data !== splat(16'd7)) begin mismatched++; $display("FAIL out_data_hold: got %h, required %h", out_data, splat(16'd7)); end
  endtask

  task automatic test_forwarding();
    step(1, 1, 9, splat(16'd10), 0, 0, 0);
    step(1, 0, 9, splat(-16'sd3), 0, 0, 0);
    step(1, 0, 9, splat(16'd1), 0, 0, 0);
    step(0, 0, 0, '0, 1, 9, 0);
    idle(1);
  endtask

  task automatic test_overflow();
    step(1, 1, 20, splat(16'h7FFF), 0, 0, 0);
    step(1, 0, 20, splat(16'd1), 0, 0, 0);
    step(0, 0, 0, '0, 1, 20, 0);
    idle(1);
  endtask

  task automatic test_relu();
    logic [DW-1:0] mixed;
    step(1, 1, 30, splat(16'hFFFB), 0, 0, 0);
    step(0, 0, 0, '0, 1, 30, 1);
    step(0, 0, 0, '0, 1, 30, 0);
    mixed = {16'd5, 16'hFFFF, 16'd0, 16'h8000, 16'h7FFF, 16'hFFFB, 16'd1, 16'hFFFE};
    step(1, 1, 31, mixed, 0, 0, 0);
    step(0, 0, 0, '0, 1, 31, 1);
    idle(1);
  endtask

  task automatic test_arbitration();
    step(1, 1, 3, splat(16'd1), 0, 0, 0);
    idle(2);
    in_valid = 1; in_first = 0; in_addr = 3; in_data = splat(16'd2);
    rd_req = 1; rd_addr = 3; relu_en = 0;
    ref_mem[3] = row_acc(ref_mem[3], splat(16'd2));
    #1;
    compared++;
    if (rd_ready !== 1'b0) begin mismatched++; $display("FAIL arb_rd_ready: got %b, required 0", rd_ready); end
    @(posedge clk); #1;
    clear_inputs();
    step(0, 0, 0, '0, 1, 3, 0);
    idle(1);
  endtask

  task automatic test_out_of_range();
    step(1, 1, 2040, splat(16'd9), 0, 0, 0);
    step(0, 0, 0, '0, 1, 2040, 0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int kind;
      a = AW'(100 + $urandom_range(0, 2));
      for (int k = 0; k < COL; k++) d[k*BW +: BW] = BW'($urandom);
      kind = $urandom_range(0, 2);
      if (kind == 2 && known[a]) step(0, 0, 0, '0, 1, a, 1'($urandom_range(0, 1)));
      else step(1, !known[a] || kind == 0, a, d, 0, 0, 0);
    end
    idle(1);
  endtask

  task automatic test_reset_midop();
    step(1, 1, 7, splat(16'd20), 0, 0, 0);
    idle(2);
    step(1, 0, 7, splat(16'd5), 0, 0, 0, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL midop_out_valid: got %b, required 0", out_valid); end
    compared++;
    if (out_data !== '0) begin mismatched++; $display("FAIL midop_out_data: got %h, required 0", out_data); end
    idle(2);
    step(0, 0, 0, '0, 1, 7, 0);
    idle(1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; known[i] = 0; end
    test_reset();
    test_first_acc();
    test_forwarding();
    test_overflow();
    test_relu();
    test_arbitration();
    test_out_of_range();
    test_back_to_back();
    test_reset_midop();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: %0d drains never returned, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
